// File: rtl/spi_slave_if.sv
// Bundle of SPI pins plus the byte-side handshake of the SPI target.
// The slave modport is the target's view; the master modport drives it.
`timescale 1ns/1ps
interface spi_slave_if;
  logic       cs_n;
  logic       sck;
  logic       mosi;
  logic [7:0] tx_data;
  logic       miso;
  logic       miso_oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_req;
  logic       active;

  modport slave (
    input  cs_n, sck, mosi, tx_data,
    output miso, miso_oe, rx_data, rx_valid, tx_req, active
  );

  modport master (
    output cs_n, sck, mosi, tx_data,
    input  miso, miso_oe, rx_data, rx_valid, tx_req, active
  );
endinterface

// File: rtl/spi_slave.sv
// SPI mode-0 target, MSB first, 8-bit frames; pins are synchronized into clk and shifted on detected edges.
// rx_valid pulses one cycle after the 8th rise; tx_req is a same-cycle strobe marking the tx_data sample.
`timescale 1ns/1ps
module spi_slave #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  spi_slave_if.slave   bus
);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("spi_slave: SYNC_STAGES must be at least 2");
  end

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  logic [SYNC_STAGES-1:0] sck_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic [SYNC_STAGES-1:0] cs_n_sync_q;
  logic                   sck_d_q;
  logic                   cs_n_d_q;

  logic s_sck, s_mosi, s_cs_n;
  logic rise, fall, cs_fall, cs_rise;

  state_e     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic [7:0] rx_shift_q, rx_shift_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       armed_q, armed_d;
  logic       tx_load;

  // Synchronizers are left out of reset so a reset inside a selection cannot fake a cs_fall.
  always_ff @(posedge clk) begin
    sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], bus.sck};
    mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.mosi};
    cs_n_sync_q <= {cs_n_sync_q[SYNC_STAGES-2:0], bus.cs_n};
    sck_d_q     <= s_sck;
    cs_n_d_q    <= s_cs_n;
  end

  assign s_sck   = sck_sync_q[SYNC_STAGES-1];
  assign s_mosi  = mosi_sync_q[SYNC_STAGES-1];
  assign s_cs_n  = cs_n_sync_q[SYNC_STAGES-1];
  assign rise    = s_sck & ~sck_d_q;
  assign fall    = ~s_sck & sck_d_q;
  assign cs_rise = s_cs_n & ~cs_n_d_q;
  assign cs_fall = ~s_cs_n & cs_n_d_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      bit_cnt_q  <= 3'd0;
      tx_shift_q <= 8'h00;
      rx_shift_q <= 8'h00;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      armed_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      armed_q    <= armed_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    armed_d    = armed_q;

    unique case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d    = SHIFT;
          tx_shift_d = bus.tx_data;
          bit_cnt_d  = 3'd0;
          rx_shift_d = 8'h00;
          armed_d    = 1'b0;
        end
      end

      SHIFT: begin
        // A completing 8th rise still delivers its byte even when the frame ends in the same cycle.
        if (rise && bit_cnt_q == 3'd7) begin
          rx_data_d  = {rx_shift_q[6:0], s_mosi};
          rx_valid_d = 1'b1;
        end

        if (cs_rise) begin
          state_d    = IDLE;
          tx_shift_d = 8'h00;
          bit_cnt_d  = 3'd0;
          armed_d    = 1'b0;
        end else if (rise) begin
          rx_shift_d = {rx_shift_q[6:0], s_mosi};
          bit_cnt_d  = bit_cnt_q + 3'd1;
          armed_d    = 1'b1;
        end else if (fall && armed_q) begin
          if (tx_load) begin
            tx_shift_d = bus.tx_data;
          end else begin
            tx_shift_d = {tx_shift_q[6:0], 1'b0};
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tx_load = 1'b0;
    if (!rst) begin
      if (state_q == IDLE) begin
        tx_load = cs_fall;
      end else begin
        tx_load = ~cs_rise & fall & armed_q & (bit_cnt_q == 3'd0);
      end
    end

    bus.tx_req   = tx_load;
    bus.miso     = tx_shift_q[7];
    bus.miso_oe  = (state_q == SHIFT);
    bus.active   = (state_q == SHIFT);
    bus.rx_data  = rx_data_q;
    bus.rx_valid = rx_valid_q;
  end

  // Eight rises can never land in consecutive clk cycles, so a valid is always a lone pulse.
  a_rx_valid_pulse: assert property (@(posedge clk) disable iff (rst) rx_valid_q |=> !rx_valid_q);
  a_idle_miso_low:  assert property (@(posedge clk) disable iff (rst) (state_q == IDLE) |-> (tx_shift_q == 8'h00));

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: directed vector table, reset/idle corner sequences, randomized frames vs. a byte-level model.
`timescale 1ns/1ps
module tb_spi_slave;

  logic clk;
  logic rst;
  spi_slave_if bus();

  spi_slave #(.SYNC_STAGES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  logic [7:0] rx_log[$];
  int         txreq_cnt = 0;
  logic [7:0] txq[$];
  logic [7:0] mosi_b[$];
  logic [7:0] tx_b[$];
  logic [7:0] got_b[$];

  typedef struct {
    int         nbits;
    bit         tf;
    bit         coin;
    logic [7:0] m0, m1, t0, t1;
    int         exp_rx;
    logic [7:0] exp_last;
    int         exp_txreq;
    logic [7:0] exp_miso0, exp_miso1;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (bus.rx_valid === 1'b1) rx_log.push_back(bus.rx_data);
  end

  // Master-side byte supplier: presents txq front, advances once per tx_req.
  always begin
    bit taken;
    @(negedge clk);
    taken = (bus.tx_req === 1'b1);
    if (taken) txreq_cnt++;
    @(posedge clk);
    #1;
    if (taken && txq.size() > 0) void'(txq.pop_front());
    bus.tx_data = (txq.size() > 0) ? txq[0] : 8'h00;
  end

  // Mode-0 master: nbits rises, optional trailing fall, optional cs_n release together with the last rise.
  task automatic run_frame(input int nbits, input int half, input bit tf, input bit coin);
    logic [7:0] mo, mi;
    txq.delete();
    foreach (tx_b[k]) txq.push_back(tx_b[k]);
    got_b.delete();
    mo = 8'h00;
    mi = 8'h00;
    cyc(2);
    bus.cs_n = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      if (i % 8 == 0) mo = mosi_b[i / 8];
      bus.mosi = mo[7];
      mo = {mo[6:0], 1'b0};
      if (i > 0) bus.sck = 1'b0;
      cyc(half);
      mi = {mi[6:0], bus.miso};
      if (i % 8 == 7) got_b.push_back(mi);
      bus.sck = 1'b1;
      if (i == nbits - 1 && coin) bus.cs_n = 1'b1;
      cyc(half);
    end
    if (tf) begin
      bus.sck = 1'b0;
      cyc(half);
    end
    bus.cs_n = 1'b1;
    cyc(half);
    bus.sck = 1'b0;
    cyc(12);
  endtask

  initial begin
    int rx0, tq0, full, nb, nbits, half, exp_tx;
    bit ab, tf, coin, seen_active, seen_miso;
    logic [7:0] last_rx;

    vecs[0] = '{8,  1'b0, 1'b0, 8'hA5, 8'h00, 8'h3C, 8'h00, 1, 8'hA5, 1, 8'h3C, 8'h00};
    vecs[1] = '{16, 1'b0, 1'b0, 8'h81, 8'h7E, 8'h55, 8'hC3, 2, 8'h7E, 2, 8'h55, 8'hC3};
    vecs[2] = '{5,  1'b0, 1'b0, 8'h12, 8'h00, 8'hAA, 8'h00, 0, 8'h7E, 1, 8'h00, 8'h00};
    vecs[3] = '{8,  1'b0, 1'b0, 8'hF0, 8'h00, 8'h0F, 8'h00, 1, 8'hF0, 1, 8'h0F, 8'h00};
    vecs[4] = '{8,  1'b0, 1'b1, 8'h1B, 8'h00, 8'h99, 8'h00, 1, 8'h1B, 1, 8'h99, 8'h00};
    vecs[5] = '{8,  1'b1, 1'b0, 8'hC6, 8'h00, 8'h5A, 8'hE7, 1, 8'hC6, 2, 8'h5A, 8'h00};

    rst = 1'b1;
    bus.cs_n = 1'b1;
    bus.sck  = 1'b0;
    bus.mosi = 1'b0;
    cyc(4);
    chk("reset_tx_req", int'(bus.tx_req), 0);
    rst = 1'b0;
    cyc(4);
    chk("reset_rx_data", int'(bus.rx_data), 0);
    chk("reset_pins", int'({bus.miso, bus.miso_oe, bus.active, bus.rx_valid}), 0);

    for (int k = 0; k < 6; k++) begin
      mosi_b = '{vecs[k].m0, vecs[k].m1, 8'h00};
      tx_b   = '{vecs[k].t0, vecs[k].t1, 8'h00};
      rx0 = rx_log.size();
      tq0 = txreq_cnt;
      run_frame(vecs[k].nbits, 4, vecs[k].tf, vecs[k].coin);
      chk($sformatf("v%0d_rx_count", k), rx_log.size() - rx0, vecs[k].exp_rx);
      chk($sformatf("v%0d_rx_data", k), int'(bus.rx_data), int'(vecs[k].exp_last));
      chk($sformatf("v%0d_tx_req_count", k), txreq_cnt - tq0, vecs[k].exp_txreq);
      if (vecs[k].exp_rx >= 1) chk($sformatf("v%0d_rx_byte0", k), int'(rx_log[rx0]), int'(vecs[k].m0));
      if (vecs[k].exp_rx >= 2) chk($sformatf("v%0d_rx_byte1", k), int'(rx_log[rx0 + 1]), int'(vecs[k].m1));
      if (vecs[k].nbits >= 8)  chk($sformatf("v%0d_miso_byte0", k), int'(got_b[0]), int'(vecs[k].exp_miso0));
      if (vecs[k].nbits >= 16) chk($sformatf("v%0d_miso_byte1", k), int'(got_b[1]), int'(vecs[k].exp_miso1));
      chk($sformatf("v%0d_idle_after", k), int'({bus.active, bus.miso_oe, bus.miso}), 0);
    end

    // Reset after three rises of a byte, then keep clocking with cs_n still low.
    txq.delete();
    txq.push_back(8'hAA);
    cyc(2);
    rx0 = rx_log.size();
    bus.cs_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.mosi = 1'b1;
      if (i > 0) bus.sck = 1'b0;
      cyc(4);
      bus.sck = 1'b1;
      cyc(4);
    end
    rst = 1'b1;
    cyc(1);
    chk("midreset_rx_data", int'(bus.rx_data), 0);
    chk("midreset_pins", int'({bus.miso, bus.miso_oe, bus.active, bus.rx_valid, bus.tx_req}), 0);
    rst = 1'b0;
    seen_active = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.sck = 1'b0;
      cyc(4);
      seen_active |= bus.active;
      bus.sck = 1'b1;
      cyc(4);
      seen_active |= bus.active;
    end
    chk("midreset_no_reentry", int'(seen_active), 0);
    bus.sck  = 1'b0;
    bus.cs_n = 1'b1;
    cyc(8);
    chk("midreset_no_rx_valid", rx_log.size() - rx0, 0);
    mosi_b = '{8'h66};
    tx_b   = '{8'h99};
    rx0 = rx_log.size();
    run_frame(8, 4, 1'b0, 1'b0);
    chk("postreset_rx_data", int'(bus.rx_data), 8'h66);
    chk("postreset_miso", int'(got_b[0]), 8'h99);
    chk("postreset_rx_count", rx_log.size() - rx0, 1);

    // sck activity while deselected.
    rx0 = rx_log.size();
    tq0 = txreq_cnt;
    seen_active = 1'b0;
    seen_miso = 1'b0;
    for (int i = 0; i < 20; i++) begin
      bus.mosi = i[0];
      bus.sck = ~bus.sck;
      cyc(4);
      seen_active |= bus.active | bus.miso_oe;
      seen_miso |= bus.miso;
    end
    bus.sck = 1'b0;
    cyc(8);
    chk("desel_rx_valid", rx_log.size() - rx0, 0);
    chk("desel_tx_req", txreq_cnt - tq0, 0);
    chk("desel_active", int'(seen_active), 0);
    chk("desel_miso", int'(seen_miso), 0);

    // Randomized frames against a byte-level model.
    last_rx = 8'h66;
    for (int r = 0; r < 12; r++) begin
      nb    = int'($urandom_range(1, 3));
      nbits = nb * 8;
      ab    = ($urandom_range(0, 3) == 0);
      if (ab) nbits = int'($urandom_range(1, nb * 8 - 1));
      tf    = !ab && ($urandom_range(0, 1) == 1);
      coin  = !ab && !tf && ($urandom_range(0, 2) == 0);
      half  = int'($urandom_range(4, 7));
      mosi_b.delete();
      tx_b.delete();
      for (int b = 0; b < 3; b++) begin
        mosi_b.push_back(8'($urandom));
        tx_b.push_back(8'($urandom));
      end
      full   = nbits / 8;
      exp_tx = 1 + full - ((nbits % 8 == 0) ? 1 : 0) + (tf ? 1 : 0);
      if (full > 0) last_rx = mosi_b[full - 1];
      rx0 = rx_log.size();
      tq0 = txreq_cnt;
      run_frame(nbits, half, tf, coin);
      chk($sformatf("r%0d_rx_count", r), rx_log.size() - rx0, full);
      chk($sformatf("r%0d_rx_data", r), int'(bus.rx_data), int'(last_rx));
      chk($sformatf("r%0d_tx_req_count", r), txreq_cnt - tq0, exp_tx);
      chk($sformatf("r%0d_active", r), int'(bus.active), 0);
      for (int b = 0; b < full; b++) begin
        chk($sformatf("r%0d_rx_byte%0d", r, b),
            (rx0 + b < rx_log.size()) ? int'(rx_log[rx0 + b]) : -1, int'(mosi_b[b]));
        chk($sformatf("r%0d_miso_byte%0d", r, b),
            (b < got_b.size()) ? int'(got_b[b]) : -1, int'(tx_b[b]));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
